// File: rtl/camera_pixel_packer.sv
// Camera capture front end: oversamples the camera bus on the Wishbone clock,
// packs pixel bytes into 32-bit words and pushes them into two alternating banks.
module camera_pixel_packer #(
  parameter int WORDS_PER_BANK = 512,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        PCLK_i,
  input  logic        VSYNC_i,
  input  logic        HREF_i,
  input  logic [7:0]  PIXEL_i,
  input  logic        Enable_i,
  input  logic        Ovf_Clr_i,
  input  logic [1:0]  Bank_Full_i,
  output logic [31:0] Push_Data_o,
  output logic        Push0_o,
  output logic        Push1_o,
  output logic        Bank_Sel_o,
  output logic [15:0] Frame_Cnt_o,
  output logic [11:0] Line_Cnt_o,
  output logic        Frame_Done_o,
  output logic        Overflow_o
);

  localparam int CW = (WORDS_PER_BANK > 1) ? $clog2(WORDS_PER_BANK) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BANK - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_WAIT_VS = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
  logic        pclk_prev_q, pclk_prev_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic        href_prev_q, href_prev_d;
  logic        push_pend_q, push_pend_d;
  logic [31:0] data_q, data_d;
  logic [11:0] line_q, line_d;
  logic [15:0] frame_q, frame_d;
  logic        done_q, done_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic        bank_q, bank_d;
  logic        ovf_q, ovf_d;

  logic        pclk_s, vs_s, hr_s, sample_s, full_s;
  logic [7:0]  pix_s;
  logic [11:0] line_inc_s;
  logic [31:0] lane_word_s;

  assign pclk_s   = sync_q[SYNC_STAGES-1][10];
  assign vs_s     = sync_q[SYNC_STAGES-1][9];
  assign hr_s     = sync_q[SYNC_STAGES-1][8];
  assign pix_s    = sync_q[SYNC_STAGES-1][7:0];
  assign sample_s = pclk_s & ~pclk_prev_q;
  assign full_s   = bank_q ? Bank_Full_i[1] : Bank_Full_i[0];

  // Strobes are gated by the full flag seen in the push cycle itself.
  assign Push0_o      = push_pend_q & ~bank_q & ~Bank_Full_i[0];
  assign Push1_o      = push_pend_q &  bank_q & ~Bank_Full_i[1];
  assign Push_Data_o  = data_q;
  assign Bank_Sel_o   = bank_q;
  assign Frame_Cnt_o  = frame_q;
  assign Line_Cnt_o   = line_q;
  assign Frame_Done_o = done_q;
  assign Overflow_o   = ovf_q;

  // FSM state register
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (!Enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_ARM;
        S_ARM:     state_d = (sample_s && !vs_s) ? S_WAIT_VS : S_ARM;
        S_WAIT_VS: state_d = (sample_s &&  vs_s) ? S_CAPTURE : S_WAIT_VS;
        S_CAPTURE: state_d = (sample_s && !vs_s) ? S_WAIT_VS : S_CAPTURE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Lane insertion of the sampled byte into the word being assembled
  always_comb begin
    case (byte_idx_q)
      2'd0:    lane_word_s = {pix_s, 24'h000000};
      2'd1:    lane_word_s = {word_q[31:24], pix_s, 16'h0000};
      2'd2:    lane_word_s = {word_q[31:16], pix_s, 8'h00};
      2'd3:    lane_word_s = {word_q[31:8], pix_s};
      default: lane_word_s = 32'h00000000;
    endcase
  end

  // Datapath, counters and push/bank bookkeeping
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], PCLK_i, VSYNC_i, HREF_i, PIXEL_i};
    pclk_prev_d = pclk_s;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    href_prev_d = href_prev_q;
    push_pend_d = 1'b0;
    data_d      = data_q;
    line_d      = line_q;
    frame_d     = frame_q;
    done_d      = 1'b0;
    line_inc_s  = (line_q == 12'hFFF) ? line_q : line_q + 12'd1;

    if (!Enable_i) begin
      byte_idx_d  = 2'd0;
      word_d      = 32'h00000000;
      href_prev_d = 1'b0;
    end else if (sample_s) begin
      case (state_q)
        S_WAIT_VS: begin
          if (vs_s) begin
            line_d      = 12'h000;
            byte_idx_d  = 2'd0;
            word_d      = 32'h00000000;
            href_prev_d = 1'b0;
          end else begin
            line_d = line_q;
          end
        end
        S_CAPTURE: begin
          if (vs_s && hr_s) begin
            href_prev_d = 1'b1;
            if (byte_idx_q == 2'd3) begin
              push_pend_d = 1'b1;
              data_d      = lane_word_s;
              byte_idx_d  = 2'd0;
              word_d      = 32'h00000000;
            end else begin
              word_d     = lane_word_s;
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end else begin
            // Lanes past byte_idx are already zero, so word_q is the padded word.
            if (href_prev_q) begin
              line_d = line_inc_s;
            end else begin
              line_d = line_q;
            end
            if (byte_idx_q != 2'd0) begin
              push_pend_d = 1'b1;
              data_d      = word_q;
            end else begin
              data_d = data_q;
            end
            byte_idx_d  = 2'd0;
            word_d      = 32'h00000000;
            href_prev_d = 1'b0;
            if (!vs_s) begin
              done_d  = 1'b1;
              frame_d = frame_q + 16'd1;
            end else begin
              frame_d = frame_q;
            end
          end
        end
        default: begin
          byte_idx_d = byte_idx_q;
        end
      endcase
    end else begin
      byte_idx_d = byte_idx_q;
    end

    if (push_pend_q) begin
      if (word_cnt_q == LAST_WORD) begin
        word_cnt_d = {CW{1'b0}};
        bank_d     = ~bank_q;
      end else begin
        word_cnt_d = word_cnt_q + CW'(1'b1);
        bank_d     = bank_q;
      end
    end else begin
      word_cnt_d = word_cnt_q;
      bank_d     = bank_q;
    end

    if (push_pend_q && full_s) begin
      ovf_d = 1'b1;
    end else if (Ovf_Clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Datapath registers
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      sync_q      <= '0;
      pclk_prev_q <= 1'b0;
      byte_idx_q  <= 2'd0;
      word_q      <= 32'h00000000;
      href_prev_q <= 1'b0;
      push_pend_q <= 1'b0;
      data_q      <= 32'h00000000;
      line_q      <= 12'h000;
      frame_q     <= 16'h0000;
      done_q      <= 1'b0;
      word_cnt_q  <= {CW{1'b0}};
      bank_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      pclk_prev_q <= pclk_prev_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      href_prev_q <= href_prev_d;
      push_pend_q <= push_pend_d;
      data_q      <= data_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
      bank_q      <= bank_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_camera_pixel_packer.sv
// Directed self-checking bench for camera_pixel_packer: framing, packing,
// bank alternation, overflow handling, enable and reset behaviour.
module tb_camera_pixel_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCLK_i = 1'b0, VSYNC_i = 1'b0, HREF_i = 1'b0;
  logic [7:0]  PIXEL_i = 8'h00;
  logic        Enable_i = 1'b0, Ovf_Clr_i = 1'b0;
  logic [1:0]  Bank_Full_i = 2'b00;
  logic [31:0] Push_Data_o;
  logic        Push0_o, Push1_o, Bank_Sel_o, Frame_Done_o, Overflow_o;
  logic [15:0] Frame_Cnt_o;
  logic [11:0] Line_Cnt_o;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, rise_cyc = 0, push_cyc = 0;
  int p0_cnt = 0, p1_cnt = 0, fd_cnt = 0, both_cnt = 0;
  logic [31:0] last_data = 32'h0;
  logic [31:0] push_log[$];

  camera_pixel_packer dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .PCLK_i(PCLK_i), .VSYNC_i(VSYNC_i),
    .HREF_i(HREF_i), .PIXEL_i(PIXEL_i), .Enable_i(Enable_i), .Ovf_Clr_i(Ovf_Clr_i),
    .Bank_Full_i(Bank_Full_i), .Push_Data_o(Push_Data_o), .Push0_o(Push0_o),
    .Push1_o(Push1_o), .Bank_Sel_o(Bank_Sel_o), .Frame_Cnt_o(Frame_Cnt_o),
    .Line_Cnt_o(Line_Cnt_o), .Frame_Done_o(Frame_Done_o), .Overflow_o(Overflow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Push / frame-done recorder, sampled on the inactive edge
  always @(negedge clk) begin
    if (Push0_o || Push1_o) begin
      last_data = Push_Data_o;
      push_cyc  = cyc;
      push_log.push_back(Push_Data_o);
    end
    if (Push0_o) p0_cnt++;
    if (Push1_o) p1_cnt++;
    if (Push0_o && Push1_o) both_cnt++;
    if (Frame_Done_o) fd_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // One camera sample: PCLK low 3 cycles, then high 4 cycles; optional clear
  // pulse lands in the push cycle of a word completed by this sample.
  task automatic pix(input logic vs, input logic hr, input logic [7:0] p, input logic clr = 1'b0);
    @(negedge clk);
    PCLK_i = 1'b0; VSYNC_i = vs; HREF_i = hr; PIXEL_i = p;
    repeat (3) @(negedge clk);
    PCLK_i = 1'b1; rise_cyc = cyc;
    repeat (2) @(negedge clk);
    @(negedge clk) Ovf_Clr_i = clr;
    @(negedge clk) Ovf_Clr_i = 1'b0;
    #1;
  endtask

  task automatic begin_frame();
    pix(1'b0, 1'b0, 8'h00);
    pix(1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk) rst = 1'b1;
    #1;
    total_cnt++; if (Push_Data_o !== 32'h0) $display("FAIL reset_data got %h want 0", Push_Data_o); else pass_cnt++;
    total_cnt++; if ({Push0_o, Push1_o, Bank_Sel_o, Frame_Done_o, Overflow_o} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {Push0_o, Push1_o, Bank_Sel_o, Frame_Done_o, Overflow_o}); else pass_cnt++;
    total_cnt++; if ({Frame_Cnt_o, Line_Cnt_o} !== 28'h0) $display("FAIL reset_counts got %h/%h want 0/0", Frame_Cnt_o, Line_Cnt_o); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int p0, fd;
    Enable_i = 1'b1;
    begin_frame();
    p0 = p0_cnt; fd = fd_cnt;
    pix(1'b1, 1'b1, 8'h11); pix(1'b1, 1'b1, 8'h22); pix(1'b1, 1'b1, 8'h33); pix(1'b1, 1'b1, 8'h44);
    total_cnt++; if (p0_cnt - p0 !== 1) $display("FAIL t1_push0 got %0d strobes want 1", p0_cnt - p0); else pass_cnt++;
    total_cnt++; if (last_data !== 32'h11223344) $display("FAIL t1_data got %h want 11223344", last_data); else pass_cnt++;
    total_cnt++; if (push_cyc - rise_cyc !== 3) $display("FAIL t1_latency got %0d want 3", push_cyc - rise_cyc); else pass_cnt++;
    total_cnt++; if (Bank_Sel_o !== 1'b0) $display("FAIL t1_bank got %b want 0", Bank_Sel_o); else pass_cnt++;
    pix(1'b1, 1'b0, 8'h00);
    total_cnt++; if (Line_Cnt_o !== 12'd1) $display("FAIL t1_line got %0d want 1", Line_Cnt_o); else pass_cnt++;
    pix(1'b0, 1'b0, 8'h00);
    total_cnt++; if (fd_cnt - fd !== 1) $display("FAIL t1_frame_done got %0d cycles want 1", fd_cnt - fd); else pass_cnt++;
    total_cnt++; if (Frame_Cnt_o !== 16'd1) $display("FAIL t1_frame_cnt got %0d want 1", Frame_Cnt_o); else pass_cnt++;
  endtask

  task automatic test_padding();
    logic [7:0] b;
    begin_frame();
    push_log.delete();
    total_cnt++; if (Line_Cnt_o !== 12'd0) $display("FAIL t2_line_clear got %0d want 0", Line_Cnt_o); else pass_cnt++;
    for (int i = 1; i <= 6; i++) begin
      b = 8'(i * 17);
      pix(1'b1, 1'b1, b);
    end
    pix(1'b1, 1'b0, 8'h00);
    total_cnt++; if (Line_Cnt_o !== 12'd1) $display("FAIL t2_line1 got %0d want 1", Line_Cnt_o); else pass_cnt++;
    pix(1'b1, 1'b1, 8'hAB); pix(1'b1, 1'b1, 8'hCD);
    pix(1'b0, 1'b0, 8'h00);
    total_cnt++; if (push_log.size() !== 3) $display("FAIL t2_push_count got %0d want 3", push_log.size()); else pass_cnt++;
    if (push_log.size() == 3) begin
      total_cnt++; if (push_log[0] !== 32'h11223344) $display("FAIL t2_word0 got %h want 11223344", push_log[0]); else pass_cnt++;
      total_cnt++; if (push_log[1] !== 32'h55660000) $display("FAIL t2_word1 got %h want 55660000", push_log[1]); else pass_cnt++;
      total_cnt++; if (push_log[2] !== 32'hABCD0000) $display("FAIL t2_word2 got %h want abcd0000", push_log[2]); else pass_cnt++;
    end
    total_cnt++; if (Line_Cnt_o !== 12'd2) $display("FAIL t2_line2 got %0d want 2", Line_Cnt_o); else pass_cnt++;
    total_cnt++; if (Frame_Cnt_o !== 16'd2) $display("FAIL t2_frame_cnt got %0d want 2", Frame_Cnt_o); else pass_cnt++;
  endtask

  task automatic test_bank_switch();
    int p0, p1;
    do_reset();
    begin_frame();
    p0 = p0_cnt; p1 = p1_cnt;
    for (int i = 0; i < 4096; i++) begin
      pix(1'b1, 1'b1, 8'(i));
      if (i == 2043) begin
        total_cnt++; if (p0_cnt - p0 !== 511 || Bank_Sel_o !== 1'b0)
          $display("FAIL t3_word511 got %0d pushes bank %b want 511 bank 0", p0_cnt - p0, Bank_Sel_o); else pass_cnt++;
      end
      if (i == 2047) begin
        total_cnt++; if (p0_cnt - p0 !== 512 || p1_cnt - p1 !== 0 || Bank_Sel_o !== 1'b1)
          $display("FAIL t3_bank0_full got p0=%0d p1=%0d bank %b want 512/0 bank 1", p0_cnt - p0, p1_cnt - p1, Bank_Sel_o); else pass_cnt++;
      end
    end
    total_cnt++; if (p0_cnt - p0 !== 512 || p1_cnt - p1 !== 512)
      $display("FAIL t3_totals got p0=%0d p1=%0d want 512/512", p0_cnt - p0, p1_cnt - p1); else pass_cnt++;
    total_cnt++; if (Bank_Sel_o !== 1'b0) $display("FAIL t3_bank_wrap got %b want 0", Bank_Sel_o); else pass_cnt++;
    total_cnt++; if (last_data !== 32'hFCFDFEFF) $display("FAIL t3_last_data got %h want fcfdfeff", last_data); else pass_cnt++;
    total_cnt++; if (both_cnt !== 0) $display("FAIL t3_dual_strobe got %0d want 0", both_cnt); else pass_cnt++;
    pix(1'b1, 1'b0, 8'h00);
    pix(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_overflow();
    int p0, p1;
    begin_frame();
    Bank_Full_i = 2'b01;
    p0 = p0_cnt; p1 = p1_cnt;
    pix(1'b1, 1'b1, 8'h01); pix(1'b1, 1'b1, 8'h02); pix(1'b1, 1'b1, 8'h03); pix(1'b1, 1'b1, 8'h04);
    total_cnt++; if (p0_cnt - p0 !== 0 || p1_cnt - p1 !== 0)
      $display("FAIL t4_drop got p0=%0d p1=%0d want 0/0", p0_cnt - p0, p1_cnt - p1); else pass_cnt++;
    total_cnt++; if (Overflow_o !== 1'b1) $display("FAIL t4_ovf_set got %b want 1", Overflow_o); else pass_cnt++;
    @(negedge clk) Ovf_Clr_i = 1'b1;
    @(negedge clk) Ovf_Clr_i = 1'b0;
    #1;
    total_cnt++; if (Overflow_o !== 1'b0) $display("FAIL t4_ovf_clr got %b want 0", Overflow_o); else pass_cnt++;
    pix(1'b1, 1'b1, 8'h05); pix(1'b1, 1'b1, 8'h06); pix(1'b1, 1'b1, 8'h07); pix(1'b1, 1'b1, 8'h08, 1'b1);
    total_cnt++; if (Overflow_o !== 1'b1) $display("FAIL t4_set_wins got %b want 1", Overflow_o); else pass_cnt++;
    Bank_Full_i = 2'b10;
    @(negedge clk) Ovf_Clr_i = 1'b1;
    @(negedge clk) Ovf_Clr_i = 1'b0;
    p0 = p0_cnt;
    pix(1'b1, 1'b1, 8'h09); pix(1'b1, 1'b1, 8'h0A); pix(1'b1, 1'b1, 8'h0B); pix(1'b1, 1'b1, 8'h0C);
    total_cnt++; if (p0_cnt - p0 !== 1 || Overflow_o !== 1'b0)
      $display("FAIL t4_other_full got p0=%0d ovf %b want 1 ovf 0", p0_cnt - p0, Overflow_o); else pass_cnt++;
    Bank_Full_i = 2'b00;
    pix(1'b1, 1'b0, 8'h00);
    pix(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_enable();
    int p0, fd;
    do_reset();
    Enable_i = 1'b0;
    pix(1'b1, 1'b0, 8'h00);
    @(negedge clk) Enable_i = 1'b1;
    p0 = p0_cnt; fd = fd_cnt;
    for (int i = 0; i < 6; i++) pix(1'b1, 1'b1, 8'h77);
    pix(1'b1, 1'b0, 8'h00);
    total_cnt++; if (p0_cnt - p0 !== 0) $display("FAIL t5_midframe got %0d pushes want 0", p0_cnt - p0); else pass_cnt++;
    begin_frame();
    pix(1'b1, 1'b1, 8'hE1); pix(1'b1, 1'b1, 8'hE2);
    @(negedge clk) Enable_i = 1'b0;
    pix(1'b1, 1'b1, 8'hE3); pix(1'b1, 1'b1, 8'hE4);
    pix(1'b1, 1'b0, 8'h00);
    total_cnt++; if (p0_cnt - p0 !== 0) $display("FAIL t5_disable got %0d pushes want 0", p0_cnt - p0); else pass_cnt++;
    @(negedge clk) Enable_i = 1'b1;
    begin_frame();
    pix(1'b1, 1'b1, 8'hA1); pix(1'b1, 1'b1, 8'hA2); pix(1'b1, 1'b1, 8'hA3); pix(1'b1, 1'b1, 8'hA4);
    total_cnt++; if (p0_cnt - p0 !== 1 || last_data !== 32'hA1A2A3A4)
      $display("FAIL t5_restart got %0d pushes data %h want 1 a1a2a3a4", p0_cnt - p0, last_data); else pass_cnt++;
    total_cnt++; if (Frame_Cnt_o !== 16'd0 || fd_cnt - fd !== 0)
      $display("FAIL t5_no_frame got cnt %0d done %0d want 0/0", Frame_Cnt_o, fd_cnt - fd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    Enable_i = 1'b1;
    Bank_Full_i = 2'b01;
    begin_frame();
    pix(1'b1, 1'b1, 8'h5A); pix(1'b1, 1'b1, 8'h5B); pix(1'b1, 1'b1, 8'h5C); pix(1'b1, 1'b1, 8'h5D);
    pix(1'b1, 1'b0, 8'h00);
    pix(1'b0, 1'b0, 8'h00);
    Bank_Full_i = 2'b00;
    total_cnt++; if (Frame_Cnt_o !== 16'd1 || Overflow_o !== 1'b1 || Push_Data_o !== 32'h5A5B5C5D)
      $display("FAIL t6_pre got cnt %0d ovf %b data %h want 1 1 5a5b5c5d", Frame_Cnt_o, Overflow_o, Push_Data_o); else pass_cnt++;
    begin_frame();
    pix(1'b1, 1'b1, 8'hC1); pix(1'b1, 1'b1, 8'hC2); pix(1'b1, 1'b1, 8'hC3);
    @(negedge clk) rst = 1'b1;
    #1;
    total_cnt++; if ({Push_Data_o, Frame_Cnt_o, Line_Cnt_o, Push0_o, Push1_o, Bank_Sel_o, Frame_Done_o, Overflow_o} !== 65'h0)
      $display("FAIL t6_reset got data %h frame %0d line %0d ovf %b want all 0", Push_Data_o, Frame_Cnt_o, Line_Cnt_o, Overflow_o); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = p0_cnt;
    begin_frame();
    pix(1'b1, 1'b1, 8'h01); pix(1'b1, 1'b1, 8'h02); pix(1'b1, 1'b1, 8'h03); pix(1'b1, 1'b1, 8'h04);
    total_cnt++; if (p0_cnt - p0 !== 1 || last_data !== 32'h01020304)
      $display("FAIL t6_repack got %0d pushes data %h want 1 01020304", p0_cnt - p0, last_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_padding();
    test_bank_switch();
    test_overflow();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
